// File: rtl/hazard3_rr_arbiter_pkg.sv
// Shared sizing helpers for the round-robin arbiter slice.
package hazard3_rr_arbiter_pkg;

  // Binary index width; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard3_onehot_priority.sv
// One-hot priority selector: keeps only the lowest (or highest) set bit of req.
module hazard3_onehot_priority #(
  parameter int W_REQ        = 4,
  parameter bit HIGHEST_WINS = 1'b0
) (
  input  logic [W_REQ-1:0] req,
  output logic [W_REQ-1:0] gnt
);

  // seen[k] = some bit earlier in scan order is set
  logic [W_REQ:0] seen;
  assign seen[0] = 1'b0;

  for (genvar k = 0; k < W_REQ; k++) begin : g_scan
    localparam int J = HIGHEST_WINS ? (W_REQ - 1 - k) : k;
    assign gnt[J]    = req[J] & ~seen[k];
    assign seen[k+1] = seen[k] | req[J];
  end

endmodule

// File: rtl/hazard3_rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant held until done, priority rotates past last owner.
module hazard3_rr_arbiter
  import hazard3_rr_arbiter_pkg::*;
#(
  parameter int W_REQ = 4,
  parameter int W_IDX = idx_w(W_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_REQ-1:0] req,
  input  logic             done,
  input  logic             lock,
  output logic [W_REQ-1:0] gnt,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             busy
);

  logic [W_IDX-1:0] ptr;
  logic [W_REQ-1:0] ones;
  logic [W_REQ-1:0] mask;
  logic [W_REQ-1:0] masked;
  logic [W_REQ-1:0] sel_masked;
  logic [W_REQ-1:0] sel_all;
  logic [W_REQ-1:0] winner;
  logic [W_IDX-1:0] winner_idx;
  logic             arb;

  assign ones   = '1;
  // Bits strictly above the last owner; ptr never exceeds W_REQ-1 so no underflow.
  assign mask   = ~(ones >> (W_IDX'(W_REQ - 1) - ptr));
  assign masked = req & mask;

  hazard3_onehot_priority #(.W_REQ(W_REQ), .HIGHEST_WINS(1'b0)) u_pri_masked (
    .req (masked),
    .gnt (sel_masked)
  );

  hazard3_onehot_priority #(.W_REQ(W_REQ), .HIGHEST_WINS(1'b0)) u_pri_all (
    .req (req),
    .gnt (sel_all)
  );

  assign winner = (|masked) ? sel_masked : sel_all;

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < W_REQ; i++)
      if (winner[i]) winner_idx = winner_idx | W_IDX'(i);
  end

  // Arbitrate when idle, or when the owner finishes without locking.
  assign arb = ~busy | (done & ~lock);

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= W_IDX'(W_REQ - 1);
    end else if (arb) begin
      gnt     <= winner;
      gnt_idx <= winner_idx;
      if (|req) ptr <= winner_idx;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_hazard3_rr_arbiter.sv
// Directed plus randomized bench for hazard3_rr_arbiter against a rotating-scan reference model.
module tb_hazard3_rr_arbiter;

  localparam int W = 4;
  localparam int WI = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          done;
  logic          lock;
  logic [W-1:0]  gnt;
  logic [WI-1:0] gnt_idx;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = idle) and last owner.
  int m_owner = -1;
  int m_last  = W - 1;

  hazard3_rr_arbiter #(.W_REQ(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .lock    (lock),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan requesters starting just after the last owner, wrapping around.
  task automatic model_step(input logic r, input logic [W-1:0] rq, input logic d, input logic l);
    int w;
    if (r) begin
      m_owner = -1;
      m_last  = W - 1;
    end else if (m_owner < 0 || (d && !l)) begin
      w = -1;
      for (int k = 1; k <= W; k++)
        if (w < 0 && rq[(m_last + k) % W]) w = (m_last + k) % W;
      m_owner = w;
      if (w >= 0) m_last = w;
    end
  endtask

  // One clock: drive, advance model, sample #1 after the edge, compare.
  task automatic cyc(input string tag, input logic r, input logic [W-1:0] rq,
                     input logic d, input logic l);
    logic [W-1:0] eg;
    rst = r; req = rq; done = d; lock = l;
    model_step(r, rq, d, l);
    @(posedge clk);
    #1;
    eg = (m_owner < 0) ? '0 : W'(1) << m_owner;
    chk({tag, ".gnt"},  32'(gnt), 32'(eg));
    chk({tag, ".idx"},  32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; lock = 1'b0;
    #2;

    // Idle after reset, done ignored when not busy
    cyc("rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc("idle_done", 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("idle_done_busy", 32'(busy), 32'd0);

    // First grant, hold, handoff with no bubble
    cyc("rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc("g1010", 1'b0, 4'b1010, 1'b0, 1'b0);
    chk("g1010_gnt", 32'(gnt), 32'b0010);
    chk("g1010_idx", 32'(gnt_idx), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1'b0, 4'b1010, 1'b0, 1'b0);
      chk("hold_gnt", 32'(gnt), 32'b0010);
    end
    cyc("handoff", 1'b0, 4'b1010, 1'b1, 1'b0);
    chk("handoff_gnt", 32'(gnt), 32'b1000);
    chk("handoff_idx", 32'(gnt_idx), 32'd3);

    // Fairness: each requester owns exactly two cycles in order 0,1,2,3,...
    cyc("rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc("fair0", 1'b0, 4'b1111, 1'b0, 1'b0);
    chk("fair0_idx", 32'(gnt_idx), 32'd0);
    for (int k = 0; k < 12; k++) begin
      cyc("fair", 1'b0, 4'b1111, logic'(k % 2), 1'b0);
      chk("fair_idx", 32'(gnt_idx), 32'(((k + 1) / 2) % 4));
    end

    // Lock keeps owner 2, unlocked done moves to 3
    cyc("lock", 1'b0, 4'b1111, 1'b1, 1'b1);
    chk("lock_gnt", 32'(gnt), 32'b0100);
    cyc("unlock", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("unlock_gnt", 32'(gnt), 32'b1000);

    // Sole requester re-wins, then release to idle
    cyc("rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc("solo", 1'b0, 4'b0010, 1'b0, 1'b0);
    cyc("solo_again", 1'b0, 4'b0010, 1'b1, 1'b0);
    chk("solo_again_gnt", 32'(gnt), 32'b0010);
    cyc("release", 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("release_gnt", 32'(gnt), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);

    // Reset mid-grant, pointer returns to favour requester 0
    cyc("rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc("own2", 1'b0, 4'b0100, 1'b0, 1'b0);
    chk("own2_gnt", 32'(gnt), 32'b0100);
    cyc("midrst", 1'b1, 4'b1111, 1'b0, 1'b0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    cyc("after_rst", 1'b0, 4'b1111, 1'b0, 1'b0);
    chk("after_rst_idx", 32'(gnt_idx), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cyc("rand", logic'($urandom_range(0, 49) == 0), W'($urandom),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
